spi_slave_engine: RTL and testbench

//  SPI target (slave) byte engine: the responder for an external SPI master on the same

---
 rtl/spi_slave_engine_if.sv | 25 ++
 rtl/spi_slave_engine.sv | 194 +++++++++++++++++++
 tb/tb_spi_slave_engine.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_engine_if.sv
// Byte-FIFO handshakes and SPI pins of the SPI target engine.
// The engine connects through the slave modport; the FIFO side and bus master use the master modport.
interface spi_slave_engine_if;
    logic [7:0] tx_fifo_data;
    logic       tx_fifo_valid;
    logic       tx_fifo_ready;
    logic [7:0] rx_fifo_data;
    logic       rx_fifo_valid;
    logic       rx_fifo_ready;
    logic       spi_sck;
    logic       spi_cs;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;

    modport slave (
        input  tx_fifo_data, tx_fifo_valid, rx_fifo_ready, spi_sck, spi_cs, spi_mosi,
        output tx_fifo_ready, rx_fifo_data, rx_fifo_valid, spi_miso, spi_miso_oe
    );

    modport master (
        output tx_fifo_data, tx_fifo_valid, rx_fifo_ready, spi_sck, spi_cs, spi_mosi,
        input  tx_fifo_ready, rx_fifo_data, rx_fifo_valid, spi_miso, spi_miso_oe
    );
endinterface

// File: rtl/spi_slave_engine.sv
// SPI target byte engine: oversamples SCK/CS/MOSI in the clk domain, pushes received
// bytes to an rx FIFO port and shifts tx FIFO bytes out on MISO, all four CPOL/CPHA modes.
module spi_slave_engine #(
    parameter logic [7:0] DUMMY_BYTE  = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_enable,
    input  logic [1:0]        spi_mode,
    input  logic              spi_msb_first,
    input  logic              clear_flags,
    spi_slave_engine_if.slave bus,
    output logic              spi_busy,
    output logic [15:0]       spi_tx_count,
    output logic [15:0]       spi_rx_count,
    output logic              spi_overflow,
    output logic              spi_underrun
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_prev_q, cs_prev_q;
    logic                   cpol_q, cpha_q, msb_q;
    logic                   cpol_d, cpha_d, msb_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_shift_q, rx_shift_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic [15:0]            tx_count_q, tx_count_d;
    logic [15:0]            rx_count_q, rx_count_d;
    logic                   ovf_q, ovf_d;
    logic                   unr_q, unr_d;

    logic       sck_s, cs_s, mosi_s, cs_fall, sck_edge, active;
    logic       lead_edge, trail_edge, sample_edge, shift_edge;
    logic       start, byte_done, load, push;
    logic [7:0] rx_next, load_byte;

    // Synchroniser chains; CS resets low so a frame already in progress at reset is never joined
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s       = sck_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall     = cs_prev_q & ~cs_s;
    assign sck_edge    = sck_s ^ sck_prev_q;
    assign active      = (state_q == ACTIVE) && spi_enable && !cs_s;
    assign lead_edge   = sck_edge && (sck_s != cpol_q);
    assign trail_edge  = sck_edge && (sck_s == cpol_q);
    assign sample_edge = active && (cpha_q ? trail_edge : lead_edge);
    assign shift_edge  = active && (cpha_q ? lead_edge : trail_edge);
    assign byte_done   = sample_edge && (bit_cnt_q == 3'd7);
    assign load        = start || byte_done;
    assign push        = byte_done && (!rx_valid_q || bus.rx_fifo_ready);
    assign rx_next     = msb_q ? {rx_shift_q[6:0], mosi_s} : {mosi_s, rx_shift_q[7:1]};
    assign load_byte   = bus.tx_fifo_valid ? bus.tx_fifo_data : DUMMY_BYTE;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (spi_enable && cs_fall) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                end
            end
            ACTIVE: begin
                if (!spi_enable || cs_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        msb_d      = msb_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        miso_d     = miso_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        tx_count_d = tx_count_q;
        rx_count_d = rx_count_q;
        miso_oe_d  = (state_d == ACTIVE);
        ovf_d      = ovf_q & ~clear_flags;
        unr_d      = unr_q & ~clear_flags;

        if (state_q == IDLE) begin
            cpol_d = spi_mode[1];
            cpha_d = spi_mode[0];
            msb_d  = spi_msb_first;
        end

        if (!active) bit_cnt_d = 3'd0;
        else if (sample_edge) bit_cnt_d = bit_cnt_q + 3'd1;

        if (sample_edge) rx_shift_d = rx_next;

        // CPHA=0 frame start puts the first bit on MISO now; otherwise it waits for the next shift edge
        if (load) begin
            if (start && !spi_mode[0]) begin
                miso_d     = spi_msb_first ? load_byte[7] : load_byte[0];
                tx_shift_d = spi_msb_first ? {load_byte[6:0], 1'b0} : {1'b0, load_byte[7:1]};
            end else begin
                tx_shift_d = load_byte;
            end
            if (bus.tx_fifo_valid) tx_count_d = tx_count_q + 16'd1;
            else unr_d = 1'b1;
        end else if (shift_edge) begin
            miso_d     = msb_q ? tx_shift_q[7] : tx_shift_q[0];
            tx_shift_d = msb_q ? {tx_shift_q[6:0], 1'b0} : {1'b0, tx_shift_q[7:1]};
        end

        if (rx_valid_q && bus.rx_fifo_ready) rx_valid_d = 1'b0;
        if (push) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            rx_count_d = rx_count_q + 16'd1;
        end else if (byte_done) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            msb_q      <= 1'b1;
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 8'd0;
            tx_shift_q <= DUMMY_BYTE;
            miso_q     <= DUMMY_BYTE[7];
            miso_oe_q  <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            tx_count_q <= 16'd0;
            rx_count_q <= 16'd0;
            ovf_q      <= 1'b0;
            unr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            msb_q      <= msb_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            miso_q     <= miso_d;
            miso_oe_q  <= miso_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
            ovf_q      <= ovf_d;
            unr_q      <= unr_d;
        end
    end

    assign bus.tx_fifo_ready = load;
    assign bus.rx_fifo_data  = rx_data_q;
    assign bus.rx_fifo_valid = rx_valid_q;
    assign bus.spi_miso      = miso_q;
    assign bus.spi_miso_oe   = miso_oe_q;
    assign spi_busy          = (state_q != IDLE);
    assign spi_tx_count      = tx_count_q;
    assign spi_rx_count      = rx_count_q;
    assign spi_overflow      = ovf_q;
    assign spi_underrun      = unr_q;

endmodule

// File: tb/tb_spi_slave_engine.sv
// Directed bench for spi_slave_engine: a bit-banged SPI master, a small tx FIFO model
// and an rx capture queue, with one task per scenario.
module tb_spi_slave_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_enable;
    logic [1:0]  spi_mode;
    logic        spi_msb_first;
    logic        clear_flags;
    logic        spi_busy;
    logic [15:0] spi_tx_count;
    logic [15:0] spi_rx_count;
    logic        spi_overflow;
    logic        spi_underrun;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         ready_pulses = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_got[$];
    logic [7:0] got;
    logic [7:0] mi [4];

    always #5 clk = ~clk;

    spi_slave_engine_if bus_if ();

    spi_slave_engine #(.DUMMY_BYTE(8'hFF), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_enable   (spi_enable),
        .spi_mode     (spi_mode),
        .spi_msb_first(spi_msb_first),
        .clear_flags  (clear_flags),
        .bus          (bus_if),
        .spi_busy     (spi_busy),
        .spi_tx_count (spi_tx_count),
        .spi_rx_count (spi_rx_count),
        .spi_overflow (spi_overflow),
        .spi_underrun (spi_underrun)
    );

    // tx FIFO model: a byte offered in a ready cycle is consumed by the following posedge
    always begin : tx_fifo_model
        bit tk;
        @(negedge clk);
        tk = bus_if.tx_fifo_ready && bus_if.tx_fifo_valid;
        if (bus_if.tx_fifo_ready) ready_pulses++;
        @(posedge clk);
        #1;
        if (tk && tx_q.size() > 0) void'(tx_q.pop_front());
        bus_if.tx_fifo_valid = (tx_q.size() > 0);
        bus_if.tx_fifo_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end

    always @(negedge clk) begin
        if (rst_n && bus_if.rx_fifo_valid && bus_if.rx_fifo_ready)
            rx_got.push_back(bus_if.rx_fifo_data);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n              = 1'b0;
        spi_enable         = 1'b1;
        spi_mode           = 2'd0;
        spi_msb_first      = 1'b1;
        clear_flags        = 1'b0;
        bus_if.spi_cs        = 1'b1;
        bus_if.spi_sck       = 1'b0;
        bus_if.spi_mosi      = 1'b0;
        bus_if.rx_fifo_ready = 1'b1;
        tx_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rx_got.delete();
        ready_pulses = 0;
    endtask

    task automatic cs_low(input logic [1:0] mode, input logic msb);
        spi_mode       = mode;
        spi_msb_first  = msb;
        bus_if.spi_sck = mode[1];
        repeat (6) @(negedge clk);
        bus_if.spi_cs = 1'b0;
        half();
    endtask

    task automatic cs_high();
        half();
        bus_if.spi_cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_xfer(input logic [1:0] mode, input logic msb, input logic [7:0] mo,
                            input int nbits, output logic [7:0] mi_o);
        int idx;
        mi_o = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            idx = msb ? 7 - i : i;
            if (!mode[0]) begin
                bus_if.spi_mosi = mo[idx];
                half();
                bus_if.spi_sck = ~mode[1];
                mi_o[idx] = bus_if.spi_miso;
                half();
                bus_if.spi_sck = mode[1];
            end else begin
                bus_if.spi_sck  = ~mode[1];
                bus_if.spi_mosi = mo[idx];
                half();
                bus_if.spi_sck = mode[1];
                mi_o[idx] = bus_if.spi_miso;
                half();
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (bus_if.spi_miso !== 1'b1) begin n_fail++; $display("FAIL reset_miso: got %b want 1", bus_if.spi_miso); end
        n_tests++; if (bus_if.spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", bus_if.spi_miso_oe); end
        n_tests++; if (spi_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", spi_busy); end
        n_tests++; if (bus_if.rx_fifo_valid !== 1'b0 || bus_if.rx_fifo_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx: got %b/%h want 0/00", bus_if.rx_fifo_valid, bus_if.rx_fifo_data); end
        n_tests++; if (bus_if.tx_fifo_ready !== 1'b0) begin n_fail++; $display("FAIL reset_txready: got %b want 0", bus_if.tx_fifo_ready); end
        n_tests++; if (spi_tx_count !== 16'd0 || spi_rx_count !== 16'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", spi_tx_count, spi_rx_count); end
        n_tests++; if (spi_overflow !== 1'b0 || spi_underrun !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b/%b want 0/0", spi_overflow, spi_underrun); end
    endtask

    task automatic test_mode0();
        do_reset();
        tx_q.push_back(8'hA5);
        cs_low(2'd0, 1'b1);
        n_tests++; if (bus_if.spi_miso_oe !== 1'b1 || spi_busy !== 1'b1) begin n_fail++; $display("FAIL mode0_oe_busy: got %b/%b want 1/1", bus_if.spi_miso_oe, spi_busy); end
        spi_xfer(2'd0, 1'b1, 8'h3C, 8, mi[0]);
        cs_high();
        got = (rx_got.size() > 0) ? rx_got[0] : 8'hxx;
        n_tests++; if (got !== 8'h3C) begin n_fail++; $display("FAIL mode0_rx: got %h want 3c", got); end
        n_tests++; if (mi[0] !== 8'hA5) begin n_fail++; $display("FAIL mode0_miso: got %h want a5", mi[0]); end
        n_tests++; if (spi_tx_count !== 16'd1 || spi_rx_count !== 16'd1) begin n_fail++; $display("FAIL mode0_counts: got %0d/%0d want 1/1", spi_tx_count, spi_rx_count); end
        // the load point at the end of the byte finds the FIFO empty
        n_tests++; if (spi_underrun !== 1'b1) begin n_fail++; $display("FAIL mode0_underrun: got %b want 1", spi_underrun); end
        n_tests++; if (spi_busy !== 1'b0 || bus_if.spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL mode0_idle: got %b/%b want 0/0", spi_busy, bus_if.spi_miso_oe); end
    endtask

    task automatic test_modes();
        logic [1:0] modes [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic       msbs  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] mos   [4] = '{8'h81, 8'h81, 8'h81, 8'h01};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rx_got.delete();
            tx_q.push_back(8'hC2);
            cs_low(modes[k], msbs[k]);
            spi_xfer(modes[k], msbs[k], mos[k], 8, mi[0]);
            cs_high();
            got = (rx_got.size() > 0) ? rx_got[0] : 8'hxx;
            n_tests++; if (got !== mos[k]) begin n_fail++; $display("FAIL modes_rx[%0d]: got %h want %h", k, got, mos[k]); end
            n_tests++; if (mi[0] !== 8'hC2) begin n_fail++; $display("FAIL modes_miso[%0d]: got %h want c2", k, mi[0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] txb [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] mob [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        do_reset();
        for (int k = 0; k < 4; k++) tx_q.push_back(txb[k]);
        tx_q.push_back(8'h55);
        cs_low(2'd3, 1'b1);
        for (int k = 0; k < 4; k++) spi_xfer(2'd3, 1'b1, mob[k], 8, mi[k]);
        cs_high();
        n_tests++; if (rx_got.size() != 4) begin n_fail++; $display("FAIL burst_rx_n: got %0d want 4", rx_got.size()); end
        for (int k = 0; k < 4; k++) begin
            got = (rx_got.size() > k) ? rx_got[k] : 8'hxx;
            n_tests++; if (got !== mob[k]) begin n_fail++; $display("FAIL burst_rx[%0d]: got %h want %h", k, got, mob[k]); end
            n_tests++; if (mi[k] !== txb[k]) begin n_fail++; $display("FAIL burst_miso[%0d]: got %h want %h", k, mi[k], txb[k]); end
        end
        // four data loads plus the prefetch taken when the last byte completes
        n_tests++; if (ready_pulses != 5) begin n_fail++; $display("FAIL burst_ready_pulses: got %0d want 5", ready_pulses); end
        n_tests++; if (spi_overflow !== 1'b0 || spi_underrun !== 1'b0) begin n_fail++; $display("FAIL burst_flags: got %b/%b want 0/0", spi_overflow, spi_underrun); end
        n_tests++; if (spi_rx_count !== 16'd4) begin n_fail++; $display("FAIL burst_rx_count: got %0d want 4", spi_rx_count); end
    endtask

    task automatic test_underrun();
        do_reset();
        cs_low(2'd0, 1'b1);
        spi_xfer(2'd0, 1'b1, 8'h12, 8, mi[0]);
        spi_xfer(2'd0, 1'b1, 8'h34, 8, mi[1]);
        cs_high();
        n_tests++; if (mi[0] !== 8'hFF || mi[1] !== 8'hFF) begin n_fail++; $display("FAIL underrun_miso: got %h %h want ff ff", mi[0], mi[1]); end
        n_tests++; if (spi_underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_flag: got %b want 1", spi_underrun); end
        n_tests++; if (spi_tx_count !== 16'd0) begin n_fail++; $display("FAIL underrun_tx_count: got %0d want 0", spi_tx_count); end
        n_tests++; if (spi_rx_count !== 16'd2) begin n_fail++; $display("FAIL underrun_rx_count: got %0d want 2", spi_rx_count); end
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        @(negedge clk);
        n_tests++; if (spi_underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clear: got %b want 0", spi_underrun); end
    endtask

    task automatic test_overflow();
        do_reset();
        bus_if.rx_fifo_ready = 1'b0;
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h03);
        cs_low(2'd0, 1'b1);
        spi_xfer(2'd0, 1'b1, 8'h5A, 8, mi[0]);
        spi_xfer(2'd0, 1'b1, 8'h6B, 8, mi[1]);
        cs_high();
        n_tests++; if (bus_if.rx_fifo_valid !== 1'b1 || bus_if.rx_fifo_data !== 8'h5A) begin n_fail++; $display("FAIL ovf_held: got %b/%h want 1/5a", bus_if.rx_fifo_valid, bus_if.rx_fifo_data); end
        n_tests++; if (spi_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", spi_overflow); end
        n_tests++; if (spi_rx_count !== 16'd1) begin n_fail++; $display("FAIL ovf_rx_count: got %0d want 1", spi_rx_count); end
        bus_if.rx_fifo_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (bus_if.rx_fifo_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain: got %b want 0", bus_if.rx_fifo_valid); end
        n_tests++; if (rx_got.size() != 1) begin n_fail++; $display("FAIL ovf_pushes: got %0d want 1", rx_got.size()); end
    endtask

    task automatic test_abort_reset();
        do_reset();
        tx_q.push_back(8'h77);
        cs_low(2'd0, 1'b1);
        spi_xfer(2'd0, 1'b1, 8'hF0, 5, mi[0]);
        cs_high();
        n_tests++; if (rx_got.size() != 0 || spi_rx_count !== 16'd0) begin n_fail++; $display("FAIL abort_push: got %0d/%0d want 0/0", rx_got.size(), spi_rx_count); end
        n_tests++; if (spi_busy !== 1'b0 || bus_if.spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b/%b want 0/0", spi_busy, bus_if.spi_miso_oe); end
        n_tests++; if (spi_overflow !== 1'b0 || spi_underrun !== 1'b0) begin n_fail++; $display("FAIL abort_flags: got %b/%b want 0/0", spi_overflow, spi_underrun); end
        cs_low(2'd0, 1'b1);
        spi_xfer(2'd0, 1'b1, 8'h0F, 3, mi[0]);
        rst_n = 1'b0;
        #1;
        n_tests++; if (spi_busy !== 1'b0 || bus_if.spi_miso_oe !== 1'b0 || bus_if.spi_miso !== 1'b1) begin n_fail++; $display("FAIL rst_async: got busy %b oe %b miso %b want 0 0 1", spi_busy, bus_if.spi_miso_oe, bus_if.spi_miso); end
        n_tests++; if (spi_tx_count !== 16'd0 || spi_rx_count !== 16'd0) begin n_fail++; $display("FAIL rst_counts: got %0d/%0d want 0/0", spi_tx_count, spi_rx_count); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ready_pulses = 0;
        spi_xfer(2'd0, 1'b1, 8'h0F, 5, mi[0]);
        n_tests++; if (spi_busy !== 1'b0 || bus_if.spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL rst_no_resume: got %b/%b want 0/0", spi_busy, bus_if.spi_miso_oe); end
        n_tests++; if (ready_pulses != 0 || bus_if.rx_fifo_valid !== 1'b0) begin n_fail++; $display("FAIL rst_quiet: got %0d/%b want 0/0", ready_pulses, bus_if.rx_fifo_valid); end
        cs_high();
        n_tests++; if (spi_rx_count !== 16'd0 || spi_busy !== 1'b0) begin n_fail++; $display("FAIL rst_after_cs: got %0d/%b want 0/0", spi_rx_count, spi_busy); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_back_to_back();
        test_underrun();
        test_overflow();
        test_abort_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
